// File: rtl/param_scan_responder.sv
// Parameter-iteration responder: answers iterate/scan queries with descriptors
// (index, width, value) of this block's own elaborated parameters.
module param_scan_responder #(
  parameter bit                SOME_BIT_PARAM = 1'b0,
  parameter int                SOME_INT_PARAM = 0,
  parameter int                VEC_W          = 8,
  parameter logic [VEC_W-1:0]  SOME_VEC_PARAM = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iter_req,
  output logic        iter_ready,
  output logic        iter_ack,
  input  logic        scan_valid,
  output logic        scan_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_null,
  output logic [1:0]  rsp_index,
  output logic [5:0]  rsp_width,
  output logic [31:0] rsp_value,
  output logic [7:0]  scan_count
);

  localparam logic [1:0] NUM_PARAMS = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    EXHAUSTED,
    RESP
  } state_t;

  // Descriptor table; slot 3 is padding so a 2-bit cursor never indexes out of range.
  logic [5:0]  entry_width [4];
  logic [31:0] entry_value [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_entry
      if (gi == 0) begin : g_bit
        assign entry_width[gi] = 6'd1;
        assign entry_value[gi] = {31'd0, SOME_BIT_PARAM};
      end else if (gi == 1) begin : g_int
        assign entry_width[gi] = 6'd32;
        assign entry_value[gi] = 32'(SOME_INT_PARAM);
      end else if (gi == 2) begin : g_vec
        assign entry_width[gi] = 6'(VEC_W);
        assign entry_value[gi] = 32'(SOME_VEC_PARAM);
      end else begin : g_pad
        assign entry_width[gi] = 6'd0;
        assign entry_value[gi] = 32'd0;
      end
    end
  endgenerate

  state_t      state_reg, state_next;
  state_t      ret_state_reg, ret_state_next;
  logic [1:0]  cursor_reg, cursor_next;
  logic [1:0]  cursor_inc;
  logic        rsp_valid_reg, rsp_valid_next;
  logic        rsp_null_reg, rsp_null_next;
  logic [1:0]  rsp_index_reg, rsp_index_next;
  logic [5:0]  rsp_width_reg, rsp_width_next;
  logic [31:0] rsp_value_reg, rsp_value_next;
  logic        iter_ack_reg, iter_ack_next;
  logic [7:0]  scan_count_reg, scan_count_next;
  logic        iter_accept;
  logic        scan_accept;

  assign iter_ready  = (state_reg != RESP);
  assign scan_ready  = (state_reg != RESP) && !iter_req;
  assign iter_accept = iter_req && iter_ready;
  assign scan_accept = scan_valid && scan_ready;
  assign cursor_inc  = cursor_reg + 2'd1;

  always_comb begin
    state_next      = state_reg;
    ret_state_next  = ret_state_reg;
    cursor_next     = cursor_reg;
    rsp_valid_next  = rsp_valid_reg;
    rsp_null_next   = rsp_null_reg;
    rsp_index_next  = rsp_index_reg;
    rsp_width_next  = rsp_width_reg;
    rsp_value_next  = rsp_value_reg;
    iter_ack_next   = 1'b0;
    scan_count_next = scan_count_reg;

    case (state_reg)
      RESP: begin
        // Fields stay frozen until the initiator takes the response.
        if (rsp_ready) begin
          state_next     = ret_state_reg;
          rsp_valid_next = 1'b0;
          if (!rsp_null_reg && (scan_count_reg != 8'hFF)) begin
            scan_count_next = scan_count_reg + 8'd1;
          end
        end
      end
      default: begin
        if (iter_accept) begin
          state_next    = ARMED;
          cursor_next   = 2'd0;
          iter_ack_next = 1'b1;
        end else if (scan_accept) begin
          state_next     = RESP;
          rsp_valid_next = 1'b1;
          if (state_reg == ARMED) begin
            rsp_null_next  = 1'b0;
            rsp_index_next = cursor_reg;
            rsp_width_next = entry_width[cursor_reg];
            rsp_value_next = entry_value[cursor_reg];
            cursor_next    = cursor_inc;
            ret_state_next = (cursor_inc == NUM_PARAMS) ? EXHAUSTED : ARMED;
          end else begin
            // No iterator open, or set exhausted: answer with an empty descriptor.
            rsp_null_next  = 1'b1;
            rsp_index_next = 2'd0;
            rsp_width_next = 6'd0;
            rsp_value_next = 32'd0;
            ret_state_next = state_reg;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ret_state_reg  <= IDLE;
      cursor_reg     <= 2'd0;
      rsp_valid_reg  <= 1'b0;
      rsp_null_reg   <= 1'b0;
      rsp_index_reg  <= 2'd0;
      rsp_width_reg  <= 6'd0;
      rsp_value_reg  <= 32'd0;
      iter_ack_reg   <= 1'b0;
      scan_count_reg <= 8'd0;
    end else begin
      state_reg      <= state_next;
      ret_state_reg  <= ret_state_next;
      cursor_reg     <= cursor_next;
      rsp_valid_reg  <= rsp_valid_next;
      rsp_null_reg   <= rsp_null_next;
      rsp_index_reg  <= rsp_index_next;
      rsp_width_reg  <= rsp_width_next;
      rsp_value_reg  <= rsp_value_next;
      iter_ack_reg   <= iter_ack_next;
      scan_count_reg <= scan_count_next;
    end
  end

  assign rsp_valid  = rsp_valid_reg;
  assign rsp_null   = rsp_null_reg;
  assign rsp_index  = rsp_index_reg;
  assign rsp_width  = rsp_width_reg;
  assign rsp_value  = rsp_value_reg;
  assign iter_ack   = iter_ack_reg;
  assign scan_count = scan_count_reg;

endmodule

// File: tb/tb_param_scan_responder.sv
// Directed bench for param_scan_responder with hand-computed descriptor values.
module tb_param_scan_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iter_req;
  logic        iter_ready;
  logic        iter_ack;
  logic        scan_valid;
  logic        scan_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_null;
  logic [1:0]  rsp_index;
  logic [5:0]  rsp_width;
  logic [31:0] rsp_value;
  logic [7:0]  scan_count;

  int errors = 0;
  int checks = 0;

  param_scan_responder #(
    .SOME_BIT_PARAM(1'b1),
    .SOME_INT_PARAM(7),
    .VEC_W(4),
    .SOME_VEC_PARAM(4'hC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .iter_req(iter_req),
    .iter_ready(iter_ready),
    .iter_ack(iter_ack),
    .scan_valid(scan_valid),
    .scan_ready(scan_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_null(rsp_null),
    .rsp_index(rsp_index),
    .rsp_width(rsp_width),
    .rsp_value(rsp_value),
    .scan_count(scan_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_iter();
    iter_req = 1'b1;
    tick();
    iter_req = 1'b0;
  endtask

  // One scan with immediate acceptance; captures the response one cycle after the request.
  task automatic do_scan(output logic v, output logic n, output logic [1:0] idx,
                         output logic [5:0] w, output logic [31:0] val);
    scan_valid = 1'b1;
    rsp_ready  = 1'b1;
    tick();
    scan_valid = 1'b0;
    v   = rsp_valid;
    n   = rsp_null;
    idx = rsp_index;
    w   = rsp_width;
    val = rsp_value;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; iter_req = 1'b0; scan_valid = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    checks++;
    if ({rsp_valid, rsp_null, iter_ack} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got valid/null/ack=%b expected 000", {rsp_valid, rsp_null, iter_ack});
    end
    checks++;
    if ({rsp_index, rsp_width, rsp_value, scan_count} !== 48'd0) begin
      errors++; $display("FAIL reset_fields: got idx=%0d w=%0d val=%h cnt=%0d expected all 0",
                         rsp_index, rsp_width, rsp_value, scan_count);
    end
    checks++;
    if ({iter_ready, scan_ready} !== 2'b11) begin
      errors++; $display("FAIL reset_ready: got iter/scan_ready=%b expected 11", {iter_ready, scan_ready});
    end
    rst_n = 1'b1;
    tick();
    $display("reset: done");
  endtask

  task automatic test_idle_null();
    logic v, n; logic [1:0] idx; logic [5:0] w; logic [31:0] val;
    do_scan(v, n, idx, w, val);
    checks++;
    if ({v, n, idx, w, val} !== {2'b11, 40'd0}) begin
      errors++; $display("FAIL idle_null: got v=%b n=%b idx=%0d w=%0d val=%h expected null zero", v, n, idx, w, val);
    end
    checks++;
    if (scan_count !== 8'd0) begin
      errors++; $display("FAIL idle_null_count: got %0d expected 0", scan_count);
    end
    $display("idle scan: v=%b null=%b count=%0d", v, n, scan_count);
  endtask

  task automatic test_iterate();
    logic v, n; logic [1:0] idx; logic [5:0] w; logic [31:0] val;
    logic [40:0] exp_rsp [4];
    exp_rsp[0] = {1'b0, 2'd0, 6'd1,  32'd1};
    exp_rsp[1] = {1'b0, 2'd1, 6'd32, 32'd7};
    exp_rsp[2] = {1'b0, 2'd2, 6'd4,  32'hC};
    exp_rsp[3] = {1'b1, 2'd0, 6'd0,  32'd0};
    do_iter();
    checks++;
    if (iter_ack !== 1'b1) begin
      errors++; $display("FAIL iter_ack_pulse: got %b expected 1", iter_ack);
    end
    tick();
    checks++;
    if (iter_ack !== 1'b0) begin
      errors++; $display("FAIL iter_ack_width: got %b expected 0", iter_ack);
    end
    for (int i = 0; i < 4; i++) begin
      do_scan(v, n, idx, w, val);
      checks++;
      if (v !== 1'b1 || {n, idx, w, val} !== exp_rsp[i]) begin
        errors++; $display("FAIL iterate_scan%0d: got v=%b n=%b idx=%0d w=%0d val=%h expected %h",
                           i, v, n, idx, w, val, exp_rsp[i]);
      end
      $display("scan %0d: null=%b idx=%0d w=%0d val=%h", i, n, idx, w, val);
    end
    checks++;
    if (scan_count !== 8'd3) begin
      errors++; $display("FAIL iterate_count: got %0d expected 3", scan_count);
    end
  endtask

  task automatic test_backpressure();
    logic v, n; logic [1:0] idx; logic [5:0] w; logic [31:0] val;
    do_iter();
    do_scan(v, n, idx, w, val);
    scan_valid = 1'b1;
    rsp_ready  = 1'b0;
    tick();
    scan_valid = 1'b0;
    iter_req   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, rsp_null, rsp_index, rsp_width, rsp_value, scan_ready, iter_ready} !==
          {2'b10, 2'd1, 6'd32, 32'd7, 2'b00}) begin
        errors++; $display("FAIL hold_cycle%0d: got v=%b n=%b idx=%0d w=%0d val=%h sr=%b ir=%b expected held (1,32,7) readies 0",
                           i, rsp_valid, rsp_null, rsp_index, rsp_width, rsp_value, scan_ready, iter_ready);
      end
      tick();
    end
    iter_req  = 1'b0;
    rsp_ready = 1'b1;
    tick();
    checks++;
    if ({rsp_valid, iter_ack} !== 2'b00) begin
      errors++; $display("FAIL hold_release: got valid/ack=%b expected 00", {rsp_valid, iter_ack});
    end
    do_scan(v, n, idx, w, val);
    checks++;
    if ({v, n, idx, w, val} !== {2'b10, 2'd2, 6'd4, 32'hC}) begin
      errors++; $display("FAIL after_hold: got v=%b n=%b idx=%0d w=%0d val=%h expected entry 2", v, n, idx, w, val);
    end
    checks++;
    if (scan_count !== 8'd6) begin
      errors++; $display("FAIL hold_count: got %0d expected 6", scan_count);
    end
    $display("backpressure: after-hold idx=%0d count=%0d", idx, scan_count);
  endtask

  task automatic test_restart();
    logic v, n; logic [1:0] idx; logic [5:0] w; logic [31:0] val;
    do_iter();
    do_scan(v, n, idx, w, val);
    do_scan(v, n, idx, w, val);
    iter_req   = 1'b1;
    scan_valid = 1'b1;
    #1;
    checks++;
    if (scan_ready !== 1'b0) begin
      errors++; $display("FAIL restart_scan_ready: got %b expected 0", scan_ready);
    end
    tick();
    iter_req   = 1'b0;
    scan_valid = 1'b0;
    checks++;
    if ({rsp_valid, iter_ack} !== 2'b01) begin
      errors++; $display("FAIL restart_accept: got valid/ack=%b expected 01", {rsp_valid, iter_ack});
    end
    do_scan(v, n, idx, w, val);
    checks++;
    if ({v, n, idx, w, val} !== {2'b10, 2'd0, 6'd1, 32'd1}) begin
      errors++; $display("FAIL restart_entry0: got v=%b n=%b idx=%0d w=%0d val=%h expected entry 0", v, n, idx, w, val);
    end
    checks++;
    if (scan_count !== 8'd9) begin
      errors++; $display("FAIL restart_count: got %0d expected 9", scan_count);
    end
    $display("restart: idx=%0d count=%0d", idx, scan_count);
  endtask

  task automatic test_reset_mid();
    logic v, n; logic [1:0] idx; logic [5:0] w; logic [31:0] val;
    do_iter();
    scan_valid = 1'b1;
    rsp_ready  = 1'b0;
    tick();
    scan_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pending: got %b expected 1", rsp_valid);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({rsp_valid, rsp_null, scan_count, iter_ready, rsp_value} !== {2'b00, 8'd0, 1'b1, 32'd0}) begin
      errors++; $display("FAIL mid_reset: got v=%b n=%b cnt=%0d ir=%b val=%h expected 0 0 0 1 0",
                         rsp_valid, rsp_null, scan_count, iter_ready, rsp_value);
    end
    rst_n = 1'b1;
    do_scan(v, n, idx, w, val);
    checks++;
    if ({v, n} !== 2'b11) begin
      errors++; $display("FAIL mid_after_null: got v=%b n=%b expected 1 1", v, n);
    end
    $display("reset mid-response: post-reset null=%b", n);
  endtask

  task automatic test_saturation();
    logic v, n; logic [1:0] idx; logic [5:0] w; logic [31:0] val;
    for (int i = 0; i < 300; i++) begin
      do_iter();
      for (int k = 0; k < 3; k++) do_scan(v, n, idx, w, val);
      if (i == 83) begin
        checks++;
        if (scan_count !== 8'd252) begin
          errors++; $display("FAIL sat_252: got %0d expected 252", scan_count);
        end
      end
      if (i == 84) begin
        checks++;
        if (scan_count !== 8'd255) begin
          errors++; $display("FAIL sat_255: got %0d expected 255", scan_count);
        end
      end
    end
    checks++;
    if (scan_count !== 8'd255) begin
      errors++; $display("FAIL sat_hold: got %0d expected 255", scan_count);
    end
    do_scan(v, n, idx, w, val);
    checks++;
    if ({v, n, scan_count} !== {2'b11, 8'd255}) begin
      errors++; $display("FAIL sat_null: got v=%b n=%b cnt=%0d expected 1 1 255", v, n, scan_count);
    end
    $display("saturation: count=%0d", scan_count);
  endtask

  initial begin
    test_reset();
    test_idle_null();
    test_iterate();
    test_backpressure();
    test_restart();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
